// File: rtl/iq_downconv_if.sv
// Sample/baseband bundle for the IQ downconverter.
// The master side drives IF samples and controls; the slave side (the
// downconverter) returns the baseband pair, its strobe and status.
interface iq_downconv_if #(
   parameter int IN_W  = 7,
   parameter int OUT_W = 9
);
   logic signed [IN_W-1:0]  I_IF;
   logic signed [IN_W-1:0]  Q_IF;
   logic                    ADC_rdy;
   logic [1:0]              mode;
   logic                    sync_clr;
   logic signed [OUT_W-1:0] I_BB;
   logic signed [OUT_W-1:0] Q_BB;
   logic                    demod_rdy;
   logic                    sat;
   logic [1:0]              lo_phase;

   modport master (
      output I_IF, Q_IF, ADC_rdy, mode, sync_clr,
      input  I_BB, Q_BB, demod_rdy, sat, lo_phase
   );

   modport slave (
      input  I_IF, Q_IF, ADC_rdy, mode, sync_clr,
      output I_BB, Q_BB, demod_rdy, sat, lo_phase
   );
endinterface

// File: rtl/iq_downconv.sv
// Quarter-rate IQ downconverter with integrate-and-dump decimation.
// Pipeline: stage 1 mixes each accepted sample with the current LO phase,
// stage 2 integrates ACC_LEN products, output stage saturates and presents
// the dump, so a block's result appears two clocks after its final sample.
module iq_downconv #(
   parameter int IN_W    = 7,
   parameter int OUT_W   = 9,
   parameter int ACC_LEN = 1
) (
   input  logic        clk,
   input  logic        reset,
   iq_downconv_if.slave bus
);
   // Products carry one extra bit so the most negative input negates exactly.
   localparam int P_W   = IN_W + 1;
   localparam int LEN_W = $clog2(ACC_LEN);
   localparam int ACC_W = P_W + LEN_W;
   localparam int CNT_W = (LEN_W > 0) ? LEN_W : 1;
   // Saturation compare width: wide enough for both the sum and the output range.
   localparam int EXT_W = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;

   localparam logic [CNT_W-1:0]        LAST_CNT = CNT_W'(ACC_LEN - 1);
   localparam logic signed [EXT_W-1:0] SAT_MAX  = EXT_W'((1 << (OUT_W - 1)) - 1);
   localparam logic signed [EXT_W-1:0] SAT_MIN  = ~SAT_MAX;

   // Control decode and sequencing
   logic                    mode_fwd;
   logic                    mode_rev;
   logic [1:0]              phase_reg;
   logic [1:0]              phase_next;
   logic [1:0]              phase_base;
   logic [1:0]              mix_phase;
   logic [CNT_W-1:0]        count_reg;
   logic [CNT_W-1:0]        count_next;
   logic [CNT_W-1:0]        count_base;
   logic                    last_sample;

   // Stage 1: mixer products
   logic signed [P_W-1:0]   i_ext;
   logic signed [P_W-1:0]   q_ext;
   logic signed [P_W-1:0]   p_i;
   logic signed [P_W-1:0]   p_q;
   logic signed [P_W-1:0]   p_i_reg;
   logic signed [P_W-1:0]   p_q_reg;
   logic                    s1_valid_reg;
   logic                    s1_last_reg;

   // Stage 2: integrator
   logic signed [ACC_W-1:0] p_i_wide;
   logic signed [ACC_W-1:0] p_q_wide;
   logic signed [ACC_W-1:0] sum_i;
   logic signed [ACC_W-1:0] sum_q;
   logic signed [ACC_W-1:0] acc_i_reg;
   logic signed [ACC_W-1:0] acc_q_reg;
   logic signed [ACC_W-1:0] sum_i_reg;
   logic signed [ACC_W-1:0] sum_q_reg;
   logic                    dump_reg;

   // Output stage
   logic signed [OUT_W-1:0] i_sat;
   logic signed [OUT_W-1:0] q_sat;
   logic                    clip_i;
   logic                    clip_q;
   logic signed [OUT_W-1:0] i_bb_reg;
   logic signed [OUT_W-1:0] q_bb_reg;
   logic                    demod_rdy_reg;
   logic                    sat_reg;

   // Clip a block sum to the signed output range; MSB of the result is the clip flag.
   function automatic logic [OUT_W:0] saturate(input logic signed [ACC_W-1:0] v);
      logic signed [EXT_W-1:0] w;
      w = EXT_W'(v);
      if (w > SAT_MAX) begin
         return {1'b1, SAT_MAX[OUT_W-1:0]};
      end else if (w < SAT_MIN) begin
         return {1'b1, SAT_MIN[OUT_W-1:0]};
      end else begin
         return {1'b0, w[OUT_W-1:0]};
      end
   endfunction

   // LO phase and block counter next-state; a clear acts before any same-cycle sample.
   always_comb begin
      mode_fwd    = (bus.mode == 2'b01);
      mode_rev    = (bus.mode == 2'b10);
      phase_base  = bus.sync_clr ? 2'd0 : phase_reg;
      mix_phase   = (mode_fwd || mode_rev) ? phase_base : 2'd0;
      count_base  = bus.sync_clr ? '0 : count_reg;
      last_sample = (count_base == LAST_CNT);
      phase_next  = phase_reg;
      count_next  = count_reg;
      if (bus.ADC_rdy) begin
         if (mode_fwd) begin
            phase_next = phase_base + 2'd1;
         end else if (mode_rev) begin
            phase_next = phase_base - 2'd1;
         end else begin
            phase_next = phase_base;
         end
         count_next = last_sample ? '0 : count_base + CNT_W'(1);
      end else if (bus.sync_clr) begin
         phase_next = 2'd0;
         count_next = '0;
      end
   end

   // Quarter-rate mixer: LO values are only 0/+1/-1, so products are swaps and negations.
   always_comb begin
      i_ext = {bus.I_IF[IN_W-1], bus.I_IF};
      q_ext = {bus.Q_IF[IN_W-1], bus.Q_IF};
      p_i   = i_ext;
      p_q   = q_ext;
      case (mix_phase)
         2'd0: begin p_i = i_ext;  p_q = q_ext;  end
         2'd1: begin p_i = q_ext;  p_q = -i_ext; end
         2'd2: begin p_i = -i_ext; p_q = -q_ext; end
         default: begin p_i = -q_ext; p_q = i_ext; end
      endcase
   end

   // Integrator add and output saturation.
   always_comb begin
      p_i_wide         = ACC_W'(p_i_reg);
      p_q_wide         = ACC_W'(p_q_reg);
      sum_i            = acc_i_reg + p_i_wide;
      sum_q            = acc_q_reg + p_q_wide;
      {clip_i, i_sat}  = saturate(sum_i_reg);
      {clip_q, q_sat}  = saturate(sum_q_reg);
   end

   // LO phase and sample-count registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase_reg <= 2'd0;
         count_reg <= '0;
      end else begin
         phase_reg <= phase_next;
         count_reg <= count_next;
      end
   end

   // Stage 1: register mixer products and tag the final sample of each block.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid_reg <= 1'b0;
         s1_last_reg  <= 1'b0;
         p_i_reg      <= '0;
         p_q_reg      <= '0;
      end else begin
         s1_valid_reg <= bus.ADC_rdy;
         if (bus.ADC_rdy) begin
            p_i_reg     <= p_i;
            p_q_reg     <= p_q;
            s1_last_reg <= last_sample;
         end
      end
   end

   // Stage 2: integrate; on the last sample hand the full sum to the output
   // stage and restart from zero. A clear drops whatever stage 1 holds.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_i_reg <= '0;
         acc_q_reg <= '0;
         sum_i_reg <= '0;
         sum_q_reg <= '0;
         dump_reg  <= 1'b0;
      end else begin
         dump_reg <= 1'b0;
         if (bus.sync_clr) begin
            acc_i_reg <= '0;
            acc_q_reg <= '0;
         end else if (s1_valid_reg) begin
            if (s1_last_reg) begin
               sum_i_reg <= sum_i;
               sum_q_reg <= sum_q;
               acc_i_reg <= '0;
               acc_q_reg <= '0;
               dump_reg  <= 1'b1;
            end else begin
               acc_i_reg <= sum_i;
               acc_q_reg <= sum_q;
            end
         end
      end
   end

   // Output stage: present a saturated dump with a one-cycle strobe; hold otherwise.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         i_bb_reg      <= '0;
         q_bb_reg      <= '0;
         demod_rdy_reg <= 1'b0;
         sat_reg       <= 1'b0;
      end else begin
         demod_rdy_reg <= dump_reg;
         if (dump_reg) begin
            i_bb_reg <= i_sat;
            q_bb_reg <= q_sat;
            sat_reg  <= clip_i | clip_q;
         end
      end
   end

   assign bus.I_BB      = i_bb_reg;
   assign bus.Q_BB      = q_bb_reg;
   assign bus.demod_rdy = demod_rdy_reg;
   assign bus.sat       = sat_reg;
   assign bus.lo_phase  = phase_reg;
endmodule

// File: tb/tb_iq_downconv.sv
// Directed bench for iq_downconv: three instances cover ACC_LEN=1, a
// saturating ACC_LEN=4/OUT_W=8 build, and an ACC_LEN=4/OUT_W=9 build.
module tb_iq_downconv;
   logic clk = 1'b0;
   logic reset;
   int   vectors     = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   iq_downconv_if #(.IN_W(7), .OUT_W(9)) b0 ();
   iq_downconv_if #(.IN_W(7), .OUT_W(8)) b1 ();
   iq_downconv_if #(.IN_W(7), .OUT_W(9)) b2 ();

   iq_downconv #(.IN_W(7), .OUT_W(9), .ACC_LEN(1)) u0 (.clk(clk), .reset(reset), .bus(b0));
   iq_downconv #(.IN_W(7), .OUT_W(8), .ACC_LEN(4)) u1 (.clk(clk), .reset(reset), .bus(b1));
   iq_downconv #(.IN_W(7), .OUT_W(9), .ACC_LEN(4)) u2 (.clk(clk), .reset(reset), .bus(b2));

   // advance to 1 ns after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      b0.I_IF = '0; b0.Q_IF = '0; b0.ADC_rdy = 1'b0; b0.mode = 2'b00; b0.sync_clr = 1'b0;
      b1.I_IF = '0; b1.Q_IF = '0; b1.ADC_rdy = 1'b0; b1.mode = 2'b00; b1.sync_clr = 1'b0;
      b2.I_IF = '0; b2.Q_IF = '0; b2.ADC_rdy = 1'b0; b2.mode = 2'b00; b2.sync_clr = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle_all();
      tick();
      tick();
      vectors++;
      if (b0.I_BB !== 9'sd0 || b0.Q_BB !== 9'sd0 || b0.demod_rdy !== 1'b0 || b0.sat !== 1'b0 || b0.lo_phase !== 2'd0) begin
         miscompares++;
         $display("FAIL reset_u0 got I=%0d Q=%0d rdy=%b sat=%b ph=%0d want all 0", b0.I_BB, b0.Q_BB, b0.demod_rdy, b0.sat, b0.lo_phase);
      end
      vectors++;
      if (b1.I_BB !== 8'sd0 || b1.Q_BB !== 8'sd0 || b1.demod_rdy !== 1'b0 || b1.sat !== 1'b0 || b1.lo_phase !== 2'd0) begin
         miscompares++;
         $display("FAIL reset_u1 got I=%0d Q=%0d rdy=%b sat=%b ph=%0d want all 0", b1.I_BB, b1.Q_BB, b1.demod_rdy, b1.sat, b1.lo_phase);
      end
      vectors++;
      if (b2.I_BB !== 9'sd0 || b2.Q_BB !== 9'sd0 || b2.demod_rdy !== 1'b0 || b2.sat !== 1'b0 || b2.lo_phase !== 2'd0) begin
         miscompares++;
         $display("FAIL reset_u2 got I=%0d Q=%0d rdy=%b sat=%b ph=%0d want all 0", b2.I_BB, b2.Q_BB, b2.demod_rdy, b2.sat, b2.lo_phase);
      end
      $display("txn reset: outputs checked on all instances");
      reset = 1'b0;
      tick();
   endtask

   // ACC_LEN=1, constant I=10 Q=3, one strobe every 5th cycle
   task automatic test_lo_direction(input logic [1:0] m, input string tag);
      int exp_i [4] = '{10, 3, -10, -3};
      int exp_q [4] = '{3, -10, -3, 10};
      int ph;
      b0.mode = m; b0.I_IF = 7'sd10; b0.Q_IF = 7'sd3;
      b0.sync_clr = 1'b1;
      tick();
      b0.sync_clr = 1'b0;
      for (int n = 0; n < 4; n++) begin
         ph = (m == 2'b01) ? n : (4 - n) % 4;
         vectors++;
         if (b0.lo_phase !== 2'(ph)) begin
            miscompares++;
            $display("FAIL %s_phase n=%0d got %0d want %0d", tag, n, b0.lo_phase, ph);
         end
         b0.ADC_rdy = 1'b1;
         tick();
         b0.ADC_rdy = 1'b0;
         tick();
         vectors++;
         if (b0.demod_rdy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_early n=%0d demod_rdy got %b want 0", tag, n, b0.demod_rdy);
         end
         tick();
         vectors++;
         if (b0.demod_rdy !== 1'b1 || b0.I_BB !== exp_i[ph] || b0.Q_BB !== exp_q[ph] || b0.sat !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_out n=%0d got rdy=%b I=%0d Q=%0d sat=%b want rdy=1 I=%0d Q=%0d sat=0",
                     tag, n, b0.demod_rdy, b0.I_BB, b0.Q_BB, b0.sat, exp_i[ph], exp_q[ph]);
         end
         $display("txn %s n=%0d phase=%0d I_BB=%0d Q_BB=%0d", tag, n, ph, b0.I_BB, b0.Q_BB);
         tick();
         vectors++;
         if (b0.demod_rdy !== 1'b0 || b0.I_BB !== exp_i[ph] || b0.Q_BB !== exp_q[ph]) begin
            miscompares++;
            $display("FAIL %s_hold n=%0d got rdy=%b I=%0d Q=%0d want rdy=0 I=%0d Q=%0d",
                     tag, n, b0.demod_rdy, b0.I_BB, b0.Q_BB, exp_i[ph], exp_q[ph]);
         end
         tick();
      end
   endtask

   // OUT_W=8, ACC_LEN=4, bypass, 8 back-to-back samples -> dumps at edges 5 and 9
   task automatic test_saturation(input logic signed [6:0] si, input logic signed [6:0] sq,
                                  input int exp_i, input int exp_q, input logic exp_sat, input string tag);
      logic pulse;
      b1.mode = 2'b00; b1.I_IF = si; b1.Q_IF = sq;
      b1.sync_clr = 1'b1;
      tick();
      b1.sync_clr = 1'b0;
      for (int e = 0; e < 12; e++) begin
         b1.ADC_rdy = (e < 8);
         tick();
         pulse = (e == 5 || e == 9);
         vectors++;
         if (b1.demod_rdy !== pulse) begin
            miscompares++;
            $display("FAIL %s_rdy edge=%0d got %b want %b", tag, e, b1.demod_rdy, pulse);
         end
         if (pulse) begin
            vectors++;
            if (b1.I_BB !== exp_i || b1.Q_BB !== exp_q || b1.sat !== exp_sat) begin
               miscompares++;
               $display("FAIL %s_out edge=%0d got I=%0d Q=%0d sat=%b want I=%0d Q=%0d sat=%b",
                        tag, e, b1.I_BB, b1.Q_BB, b1.sat, exp_i, exp_q, exp_sat);
            end
            $display("txn %s edge=%0d I_BB=%0d Q_BB=%0d sat=%b", tag, e, b1.I_BB, b1.Q_BB, b1.sat);
         end
      end
      b1.ADC_rdy = 1'b0;
   endtask

   // ACC_LEN=1, mode 01, strobe held 8 cycles -> 8 consecutive dumps at edges 2..9
   task automatic test_back_to_back();
      int exp_i [4] = '{10, 3, -10, -3};
      int exp_q [4] = '{3, -10, -3, 10};
      logic pulse;
      int ph;
      b0.mode = 2'b01; b0.I_IF = 7'sd10; b0.Q_IF = 7'sd3;
      b0.sync_clr = 1'b1;
      tick();
      b0.sync_clr = 1'b0;
      for (int e = 0; e < 11; e++) begin
         b0.ADC_rdy = (e < 8);
         tick();
         pulse = (e >= 2 && e <= 9);
         vectors++;
         if (b0.demod_rdy !== pulse) begin
            miscompares++;
            $display("FAIL b2b_rdy edge=%0d got %b want %b", e, b0.demod_rdy, pulse);
         end
         if (pulse) begin
            ph = (e - 2) % 4;
            vectors++;
            if (b0.I_BB !== exp_i[ph] || b0.Q_BB !== exp_q[ph]) begin
               miscompares++;
               $display("FAIL b2b_out edge=%0d got I=%0d Q=%0d want I=%0d Q=%0d", e, b0.I_BB, b0.Q_BB, exp_i[ph], exp_q[ph]);
            end
            $display("txn b2b edge=%0d phase=%0d I_BB=%0d Q_BB=%0d", e, ph, b0.I_BB, b0.Q_BB);
         end
      end
      b0.ADC_rdy = 1'b0;
   endtask

   // ACC_LEN=4, mode 01: two samples, then clear with a sample; the block of
   // (10,3)@0 (5,-7)@1 (-4,6)@2 (8,2)@3 sums to I=10-7+4-2=5, Q=3-5-6+8=0
   task automatic test_sync_clr();
      int ti [6] = '{20, 20, 10, 5, -4, 8};
      int tq [6] = '{5, 5, 3, -7, 6, 2};
      logic tc [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      logic pulse;
      b2.mode = 2'b01;
      b2.sync_clr = 1'b1;
      tick();
      b2.sync_clr = 1'b0;
      for (int e = 0; e < 10; e++) begin
         if (e < 6) begin
            b2.ADC_rdy = 1'b1; b2.I_IF = 7'(ti[e]); b2.Q_IF = 7'(tq[e]); b2.sync_clr = tc[e];
         end else begin
            b2.ADC_rdy = 1'b0; b2.sync_clr = 1'b0;
         end
         tick();
         pulse = (e == 7);
         vectors++;
         if (b2.demod_rdy !== pulse) begin
            miscompares++;
            $display("FAIL clr_rdy edge=%0d got %b want %b", e, b2.demod_rdy, pulse);
         end
         if (e == 2) begin
            vectors++;
            if (b2.lo_phase !== 2'd1) begin
               miscompares++;
               $display("FAIL clr_phase got %0d want 1", b2.lo_phase);
            end
         end
         if (pulse) begin
            vectors++;
            if (b2.I_BB !== 9'sd5 || b2.Q_BB !== 9'sd0 || b2.sat !== 1'b0) begin
               miscompares++;
               $display("FAIL clr_out got I=%0d Q=%0d sat=%b want I=5 Q=0 sat=0", b2.I_BB, b2.Q_BB, b2.sat);
            end
            $display("txn sync_clr edge=%0d I_BB=%0d Q_BB=%0d", e, b2.I_BB, b2.Q_BB);
         end
      end
      b2.sync_clr = 1'b0;
   endtask

   // Reset between edges with a completed block still in the pipe; then a fresh block
   task automatic test_reset_mid_block();
      int ti [5] = '{10, 5, -4, 8, 1};
      int tq [5] = '{3, -7, 6, 2, 1};
      logic pulse;
      b2.mode = 2'b01;
      b2.sync_clr = 1'b1;
      tick();
      b2.sync_clr = 1'b0;
      for (int e = 0; e < 5; e++) begin
         b2.ADC_rdy = 1'b1; b2.I_IF = 7'(ti[e]); b2.Q_IF = 7'(tq[e]);
         tick();
      end
      b2.ADC_rdy = 1'b0;
      #2 reset = 1'b1;
      #1;
      vectors++;
      if (b2.I_BB !== 9'sd0 || b2.Q_BB !== 9'sd0 || b2.demod_rdy !== 1'b0 || b2.sat !== 1'b0 || b2.lo_phase !== 2'd0) begin
         miscompares++;
         $display("FAIL async_rst got I=%0d Q=%0d rdy=%b sat=%b ph=%0d want all 0", b2.I_BB, b2.Q_BB, b2.demod_rdy, b2.sat, b2.lo_phase);
      end
      $display("txn async_reset I_BB=%0d Q_BB=%0d lo_phase=%0d", b2.I_BB, b2.Q_BB, b2.lo_phase);
      #2 reset = 1'b0;
      for (int e = 0; e < 2; e++) begin
         tick();
         vectors++;
         if (b2.demod_rdy !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_pending cycle=%0d demod_rdy got %b want 0", e, b2.demod_rdy);
         end
      end
      vectors++;
      if (b2.lo_phase !== 2'd0) begin
         miscompares++;
         $display("FAIL rst_phase got %0d want 0", b2.lo_phase);
      end
      for (int e = 0; e < 8; e++) begin
         if (e < 4) begin
            b2.ADC_rdy = 1'b1; b2.I_IF = 7'(ti[e]); b2.Q_IF = 7'(tq[e]);
         end else begin
            b2.ADC_rdy = 1'b0;
         end
         tick();
         pulse = (e == 5);
         vectors++;
         if (b2.demod_rdy !== pulse) begin
            miscompares++;
            $display("FAIL rst_rdy edge=%0d got %b want %b", e, b2.demod_rdy, pulse);
         end
         if (pulse) begin
            vectors++;
            if (b2.I_BB !== 9'sd5 || b2.Q_BB !== 9'sd0) begin
               miscompares++;
               $display("FAIL rst_out got I=%0d Q=%0d want I=5 Q=0", b2.I_BB, b2.Q_BB);
            end
            $display("txn after_reset edge=%0d I_BB=%0d Q_BB=%0d", e, b2.I_BB, b2.Q_BB);
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      idle_all();
      test_reset();
      test_lo_direction(2'b01, "mode01");
      test_lo_direction(2'b10, "mode10");
      test_saturation(7'sd63, -7'sd64, 127, -128, 1'b1, "sat_clip");
      test_saturation(7'sd31, -7'sd32, 124, -128, 1'b0, "sat_fit");
      test_back_to_back();
      test_sync_clr();
      test_reset_mid_block();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
